// File: rtl/deser_serpar_multi.sv
// deser_serpar_multi
//   Multi-lane serial-to-parallel framer. Each lane hunts for a header
//   pattern in its qualified serial bit stream, then assembles a
//   WORD_WIDTH-bit word MSB first and presents it with a one-cycle strobe.
//
// Ports
//   clock     : single clock (serial bit rate domain)
//   res       : synchronous, active-high reset
//   run       : enable; low forces every lane back to IDLE
//   ser       : serial data bit per lane
//   ser_en    : per-lane bit valid; ser[i] is consumed only when set
//   par       : parallel words, lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   write     : one-cycle strobe per lane qualifying its par slice
//   word_cnt  : per-lane emitted word count, lane i at [i*16 +: 16]
//   state_dbg : per-lane FSM state (00 IDLE, 01 HUNT, 10 SHIFT)
module deser_serpar_multi #(
  parameter int                 CHANNELS    = 2,
  parameter int                 WORD_WIDTH  = 16,
  parameter int                 HDR_LEN     = 4,
  parameter logic [HDR_LEN-1:0] HDR_PATTERN = 4'b0111
) (
  input  logic                           clock,
  input  logic                           res,
  input  logic                           run,
  input  logic [CHANNELS-1:0]            ser,
  input  logic [CHANNELS-1:0]            ser_en,
  output logic [CHANNELS*WORD_WIDTH-1:0] par,
  output logic [CHANNELS-1:0]            write,
  output logic [CHANNELS*16-1:0]         word_cnt,
  output logic [CHANNELS*2-1:0]          state_dbg
);

  localparam int BCW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int HCW = $clog2(HDR_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HUNT  = 2'b01,
    ST_SHIFT = 2'b10
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    state_t                  state_q, state_d;
    logic [HDR_LEN-1:0]      hdr_q, hdr_d, hdr_shift;
    logic [HCW-1:0]          hcnt_q, hcnt_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d, word_shift;
    logic [BCW-1:0]          bcnt_q, bcnt_d;
    logic [WORD_WIDTH-1:0]   par_q, par_d;
    logic                    write_q, write_d;
    logic [15:0]             cnt_q, cnt_d;

    // New bit enters at the LSB; the oldest bit falls off the top.
    assign hdr_shift  = HDR_LEN'({hdr_q, ser[i]});
    assign word_shift = WORD_WIDTH'({word_q, ser[i]});

    always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      hcnt_d  = hcnt_q;
      word_d  = word_q;
      bcnt_d  = bcnt_q;
      par_d   = par_q;
      write_d = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d = ST_HUNT;
            hdr_d   = '0;
            hcnt_d  = '0;
          end
        end
        ST_HUNT: begin
          if (!run) begin
            state_d = ST_IDLE;
          end else if (ser_en[i]) begin
            hdr_d = hdr_shift;
            // hcnt saturates at HDR_LEN: it only has to prove that the
            // register holds a full window of bits taken in this hunt.
            if (hcnt_q != HCW'(HDR_LEN)) hcnt_d = hcnt_q + HCW'(1);
            if ((hdr_shift == HDR_PATTERN) && (hcnt_q >= HCW'(HDR_LEN - 1))) begin
              state_d = ST_SHIFT;
              bcnt_d  = '0;
            end
          end
        end
        ST_SHIFT: begin
          if (ser_en[i]) begin
            word_d = word_shift;
            bcnt_d = bcnt_q + BCW'(1);
            if (bcnt_q == BCW'(WORD_WIDTH - 1)) begin
              par_d   = word_shift;
              write_d = 1'b1;
              cnt_d   = cnt_q + 16'd1;
              state_d = ST_HUNT;
              hdr_d   = '0;
              hcnt_d  = '0;
              bcnt_d  = '0;
            end
          end
          // A word completing on the same edge is still emitted above;
          // dropping run only redirects the next state.
          if (!run) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clock) begin
      if (res) begin
        state_q <= ST_IDLE;
        hdr_q   <= '0;
        hcnt_q  <= '0;
        word_q  <= '0;
        bcnt_q  <= '0;
        par_q   <= '0;
        write_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        hdr_q   <= hdr_d;
        hcnt_q  <= hcnt_d;
        word_q  <= word_d;
        bcnt_q  <= bcnt_d;
        par_q   <= par_d;
        write_q <= write_d;
        cnt_q   <= cnt_d;
      end
    end

    assign par[i*WORD_WIDTH +: WORD_WIDTH] = par_q;
    assign write[i]                        = write_q;
    assign word_cnt[i*16 +: 16]            = cnt_q;
    assign state_dbg[i*2 +: 2]             = state_q;
  end

endmodule
